alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares one ALU between NUM_REQ independent requesters, e.g. the control unit and register-file write-back paths, under round-robin arbitration. It accepts one operation at a time over a valid/ready request handshake and drives the ALU's start/op/operand inputs. It waits for the ALU's done pulse, then returns the result with the winning requester's ID over a valid/ready response handshake. It sits in cpu between the requesters and alu.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- DATA_W, 32, operand/result width
- TIMEOUT_CYCLES, 64, maximum EXEC cycles before abort (used only with ALU_ARB_TIMEOUT_EN)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_op  in  NUM_REQ  per-requester op: 0 = add, 1 = multiply
- req_a  in  NUM_REQ*DATA_W  operand A, requester i at bits [i*DATA_W +: DATA_W]
- req_b  in  NUM_REQ*DATA_W  operand B, same packing
- alu_go  out  1  one-cycle start pulse to ALU
- alu_op  out  1  op to ALU
- alu_a, alu_b  out  DATA_W  operands to ALU
- alu_done  in  1  ALU completion pulse
- alu_result  in  DATA_W  ALU result, valid with alu_done
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  $clog2(NUM_REQ)  requester index of response
- rsp_data  out  DATA_W  result
- rsp_err  out  1  ALU timed out; rsp_data = 0

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE
  - If any req_valid is high, assert req_ready for the round-robin winner only.
  - Latch its op, operands and ID.
  - Advance the pointer to (winner+1) mod NUM_REQ.
  - Go to EXEC.
- Round-robin search starts at the pointer index and wraps. The pointer is 0 after reset and is unchanged when no request is accepted.
- EXEC
  - alu_go is high on the first EXEC cycle only.
  - alu_op/alu_a/alu_b hold the latched values for all of EXEC.
  - alu_done is sampled from the second EXEC cycle onward; alu_done coincident with alu_go is ignored.
  - On alu_done: register alu_result into rsp_data, clear rsp_err, go to RESP.
- RESP
  - rsp_valid is high; rsp_id/rsp_data/rsp_err are stable until rsp_ready.
  - On rsp_valid&rsp_ready, go to IDLE.
- req_ready is low in EXEC and RESP, so no new request is accepted while busy.
- alu_done outside EXEC is ignored.
- Reset values:
  - State IDLE, pointer 0.
  - req_ready 0, alu_go 0, alu_op 0, alu_a/alu_b 0.
  - rsp_valid 0, rsp_id 0, rsp_data 0, rsp_err 0.
- Reset mid-operation abandons the op: no response and no further alu_go.

## Timing
- Request accept at cycle T (req_valid&req_ready). alu_go at T+1.
- alu_done earliest at T+2, at cycle D.
- rsp_valid from D+1. Handshake at R; next accept possible at R+1.
- Minimum 4 cycles per op with a 1-cycle ALU.
- req_ready is combinational from req_valid and state/pointer. All other outputs are registered.

## Configuration
- ALU_ARB_TIMEOUT_EN defined:
  - A counter clears on EXEC entry and increments each EXEC cycle.
  - If TIMEOUT_CYCLES EXEC cycles pass with no alu_done, go to RESP with rsp_err=1 and rsp_data=0.
  - alu_done on the final permitted cycle wins (rsp_err=0).
- ALU_ARB_TIMEOUT_EN undefined: no counter, EXEC waits indefinitely, rsp_err is tied 0 (port retained).

## Structure
- Package alu_arb_pkg holds:
  - state enum (IDLE, EXEC, RESP)
  - op constants ALU_OP_ADD=1'b0, ALU_OP_MUL=1'b1
- Sub-module rr_arbiter:
  - NUM_REQ-wide round-robin grant with internal pointer register.
  - Inputs: req vector and an advance strobe. Output: one-hot grant plus index.

## Test plan
- Single request: req 2, add, a=5, b=7; ALU model returns 12 one cycle after alu_go -> alu_go at T+1; rsp_valid at T+3 with id=2, data=12, err=0.
- All four requesting continuously after reset -> grants in order 0,1,2,3,0; each rsp_id matches.
- rsp_ready held low 5 cycles -> rsp_valid, rsp_id and rsp_data stable; no req_ready until the cycle after the handshake.
- Spurious alu_done in IDLE and coincident with alu_go -> ignored; the response is produced only from a later done.
- Reset asserted in EXEC with a pending alu_done -> next cycle all outputs at reset values; no response; pointer back to 0.
- With ALU_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, ALU never responds -> rsp_valid after 8 EXEC cycles with err=1, data=0. A second run with done on EXEC cycle 8 -> err=0.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter: FSM state encoding and ALU op codes.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic ALU_OP_ADD = 1'b0;
    localparam logic ALU_OP_MUL = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from an internal pointer that moves past
// the winner whenever the advance strobe is high.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       advance,
    output logic [NUM_REQ-1:0]         grant_c,
    output logic [$clog2(NUM_REQ)-1:0] idx_c
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] cand;
    int               sum;

    // Walk offsets from the far end so the candidate closest to ptr overwrites last.
    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        cand    = '0;
        sum     = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            sum = int'(ptr) + i;
            if (sum >= int'(NUM_REQ)) begin
                sum = sum - int'(NUM_REQ);
            end
            cand = IDX_W'(sum);
            if (req[cand]) begin
                grant_c       = '0;
                grant_c[cand] = 1'b1;
                idx_c         = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (idx_c == IDX_W'(NUM_REQ - 1)) ? '0 : idx_c + 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NUM_REQ requesters with round-robin arbitration and a registered
// response path. Define ALU_ARB_TIMEOUT_EN to abort EXEC after TIMEOUT_CYCLES cycles.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ-1:0]          req_op,
    input  logic [NUM_REQ*DATA_W-1:0]   req_a,
    input  logic [NUM_REQ*DATA_W-1:0]   req_b,
    output logic                        alu_go,
    output logic                        alu_op,
    output logic [DATA_W-1:0]           alu_a,
    output logic [DATA_W-1:0]           alu_b,
    input  logic                        alu_done,
    input  logic [DATA_W-1:0]           alu_result,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        rsp_err
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("alu_arbiter: NUM_REQ must be 2..16 and TIMEOUT_CYCLES nonzero");
    end

    state_t             state;
    state_t             state_nxt;
    logic [NUM_REQ-1:0] grant_c;
    logic [IDX_W-1:0]   grant_idx_c;
    logic               advance_c;
    logic               timeout_c;

    logic               sel_op;
    logic [DATA_W-1:0]  sel_a;
    logic [DATA_W-1:0]  sel_b;

    logic               go_nxt;
    logic               op_nxt;
    logic [DATA_W-1:0]  a_nxt;
    logic [DATA_W-1:0]  b_nxt;
    logic               valid_nxt;
    logic [IDX_W-1:0]   id_nxt;
    logic [DATA_W-1:0]  data_nxt;
    logic               err_nxt;

    assign advance_c = (state == IDLE) && (|req_valid);
    assign req_ready = (state == IDLE) ? grant_c : '0;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (advance_c),
        .grant_c (grant_c),
        .idx_c   (grant_idx_c)
    );

    // Operand mux for the granted requester.
    always_comb begin
        sel_op = ALU_OP_ADD;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant_c[i]) begin
                sel_op = req_op[i];
                sel_a  = req_a[i*DATA_W +: DATA_W];
                sel_b  = req_b[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] exec_cnt;

    // Holds (EXEC cycle number - 1); zero outside EXEC so it is clear on entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            exec_cnt <= '0;
        end else if (state == EXEC) begin
            exec_cnt <= exec_cnt + 1'b1;
        end else begin
            exec_cnt <= '0;
        end
    end

    assign timeout_c = (exec_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_c = 1'b0;
`endif

    // alu_go is high only on the first EXEC cycle, so it masks a coincident done.
    always_comb begin
        state_nxt = state;
        go_nxt    = 1'b0;
        op_nxt    = alu_op;
        a_nxt     = alu_a;
        b_nxt     = alu_b;
        valid_nxt = rsp_valid;
        id_nxt    = rsp_id;
        data_nxt  = rsp_data;
        err_nxt   = rsp_err;
        unique case (state)
            IDLE: begin
                if (|req_valid) begin
                    state_nxt = EXEC;
                    go_nxt    = 1'b1;
                    op_nxt    = sel_op;
                    a_nxt     = sel_a;
                    b_nxt     = sel_b;
                    id_nxt    = grant_idx_c;
                end
            end
            EXEC: begin
                if (alu_done && !alu_go) begin
                    state_nxt = RESP;
                    valid_nxt = 1'b1;
                    data_nxt  = alu_result;
                    err_nxt   = 1'b0;
                end else if (timeout_c) begin
                    state_nxt = RESP;
                    valid_nxt = 1'b1;
                    data_nxt  = '0;
                    err_nxt   = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            alu_go    <= 1'b0;
            alu_op    <= ALU_OP_ADD;
            alu_a     <= '0;
            alu_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            alu_go    <= go_nxt;
            alu_op    <= op_nxt;
            alu_a     <= a_nxt;
            alu_b     <= b_nxt;
            rsp_valid <= valid_nxt;
            rsp_id    <= id_nxt;
            rsp_data  <= data_nxt;
            rsp_err   <= err_nxt;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed plus randomized bench for alu_arbiter with a round-robin reference model and
// a behavioural ALU; the timeout scenarios run when ALU_ARB_TIMEOUT_EN is defined.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int unsigned N   = 4;
    localparam int unsigned W   = 32;
    localparam int unsigned IW  = 2;
    localparam int unsigned TMO = 8;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N-1:0]     req_op;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic             alu_go;
    logic             alu_op;
    logic [W-1:0]     alu_a;
    logic [W-1:0]     alu_b;
    logic             alu_done;
    logic [W-1:0]     alu_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IW-1:0]    rsp_id;
    logic [W-1:0]     rsp_data;
    logic             rsp_err;

    int n_cmp = 0;
    int n_bad = 0;
    int ref_ptr = 0;

    alu_arbiter #(
        .NUM_REQ        (N),
        .DATA_W         (W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_go     (alu_go),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // First requester at or after the model pointer, wrapping.
    function automatic int winner(input logic [N-1:0] rv);
        for (int i = 0; i < int'(N); i++) begin
            if (rv[(ref_ptr + i) % N]) return (ref_ptr + i) % N;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] alu_fn(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = a * b;
        return (op == ALU_OP_MUL) ? p[W-1:0] : a + b;
    endfunction

    function automatic logic [N-1:0] onehot(input int idx);
        logic [N-1:0] g;
        g = '0;
        g[idx] = 1'b1;
        return g;
    endfunction

    task automatic set_operands();
        for (int i = 0; i < int'(N); i++) begin
            req_a[i*W +: W] = $urandom;
            req_b[i*W +: W] = $urandom;
            req_op[i]       = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_alu_go"}, alu_go, 0);
        chk({tag, "_alu_op"}, alu_op, 0);
        chk({tag, "_alu_a"}, alu_a, 0);
        chk({tag, "_alu_b"}, alu_b, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_id"}, rsp_id, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
    endtask

    // One full transaction: called at a cycle start with req_* already driven.
    // lat = cycles from alu_go to done; hold = cycles rsp_ready is held low.
    task automatic run_op(input int lat, input int hold, input bit spur_go);
        int           w;
        logic         eo;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic [W-1:0] er;
        #1;
        w = winner(req_valid);
        chk("grant", req_ready, onehot(w));
        eo = req_op[w];
        ea = req_a[w*W +: W];
        eb = req_b[w*W +: W];
        er = alu_fn(eo, ea, eb);
        ref_ptr = (w + 1) % N;
        step();
        chk("alu_go_first", alu_go, 1);
        chk("alu_op", alu_op, eo);
        chk("alu_a", alu_a, ea);
        chk("alu_b", alu_b, eb);
        chk("ready_busy", req_ready, 0);
        set_operands();
        if (spur_go) begin
            alu_done   = 1'b1;
            alu_result = ~er;
        end
        for (int k = 1; k <= lat; k++) begin
            step();
            alu_done = 1'b0;
            chk("alu_go_low", alu_go, 0);
            chk("rsp_valid_early", rsp_valid, 0);
            if (k == lat) begin
                alu_done   = 1'b1;
                alu_result = alu_fn(alu_op, alu_a, alu_b);
            end
        end
        step();
        alu_done = 1'b0;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_id", rsp_id, w);
        chk("rsp_data", rsp_data, er);
        chk("rsp_err", rsp_err, 0);
        for (int h = 0; h < hold; h++) begin
            step();
            chk("hold_valid", rsp_valid, 1);
            chk("hold_id", rsp_id, w);
            chk("hold_data", rsp_data, er);
            chk("hold_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        chk("hs_ready", req_ready, 0);
        step();
        rsp_ready = 1'b0;
        chk("post_hs_valid", rsp_valid, 0);
    endtask

    initial begin
        int w;
        clk        = 1'b0;
        rst        = 1'b1;
        req_valid  = '0;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        alu_done   = 1'b0;
        alu_result = '0;
        rsp_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("por");
        rst = 1'b0;
        step();

        // Single add from requester 2: 5 + 7.
        set_operands();
        req_a[2*W +: W] = 32'd5;
        req_b[2*W +: W] = 32'd7;
        req_op[2]       = ALU_OP_ADD;
        req_valid       = 4'b0100;
        run_op(1, 0, 1'b0);
        req_valid = '0;
        chk("single_data_12", rsp_data, 32'd12);

        // Fresh reset, then all four requesting continuously.
        rst = 1'b1;
        step();
        rst = 1'b0;
        ref_ptr = 0;
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            set_operands();
            run_op(1, 0, 1'b0);
        end

        // Response back-pressure for 5 cycles.
        set_operands();
        run_op(2, 5, 1'b0);
        req_valid = '0;

        // Spurious done in IDLE, then coincident with alu_go.
        alu_done   = 1'b1;
        alu_result = 32'hBAD0_BAD0;
        step();
        alu_done = 1'b0;
        chk("spur_idle_valid", rsp_valid, 0);
        chk("spur_idle_go", alu_go, 0);
        step();
        set_operands();
        req_valid = 4'b0001;
        run_op(3, 0, 1'b1);
        req_valid = '0;

        // Reset during EXEC with a pending done.
        set_operands();
        req_valid = 4'b0100;
        #1;
        w = winner(req_valid);
        chk("rst_grant", req_ready, onehot(w));
        step();
        chk("rst_go", alu_go, 1);
        step();
        rst        = 1'b1;
        alu_done   = 1'b1;
        alu_result = 32'hDEAD_BEEF;
        req_valid  = '0;
        step();
        check_reset_vals("mid");
        rst      = 1'b0;
        alu_done = 1'b0;
        ref_ptr  = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("after_rst_valid", rsp_valid, 0);
            chk("after_rst_go", alu_go, 0);
        end
        set_operands();
        req_valid = 4'b1111;
        run_op(1, 0, 1'b0);
        req_valid = '0;

        // Randomized traffic.
        for (int it = 0; it < 24; it++) begin
            set_operands();
            req_valid = N'($urandom_range(1, (1 << N) - 1));
            run_op(int'($urandom_range(1, 4)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            req_valid = '0;
            if ($urandom_range(0, 1) == 1) step();
        end

`ifdef ALU_ARB_TIMEOUT_EN
        // ALU never answers: abort after TMO EXEC cycles.
        set_operands();
        req_valid = 4'b1000;
        #1;
        w = winner(req_valid);
        chk("tmo_grant", req_ready, onehot(w));
        ref_ptr = (w + 1) % N;
        step();
        req_valid = '0;
        chk("tmo_go", alu_go, 1);
        for (int k = 2; k <= int'(TMO); k++) begin
            step();
            chk("tmo_wait", rsp_valid, 0);
        end
        step();
        chk("tmo_valid", rsp_valid, 1);
        chk("tmo_err", rsp_err, 1);
        chk("tmo_data", rsp_data, 0);
        chk("tmo_id", rsp_id, w);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("tmo_post", rsp_valid, 0);

        // Done on the final permitted EXEC cycle wins.
        set_operands();
        req_valid = 4'b0001;
        run_op(int'(TMO) - 1, 0, 1'b0);
        req_valid = '0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
